// File: rtl/dfe_offset_cal_ctrl.sv
// DFE ADC offset calibration sequencer: 3-bit successive-approximation trim of four interleaved channels.
// Optional feature macro DFE_CAL_SAT_FLAG_EN adds SAT_FLAG, flagging channels whose final trim railed.
module dfe_offset_cal_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int ACC_LOG2   = 6
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       START,
  input  logic [5:0] IN_DFE_1_p,
  input  logic [5:0] IN_DFE_1_n,
  input  logic [5:0] IN_DFE_2_p,
  input  logic [5:0] IN_DFE_2_n,
  input  logic [5:0] IN_DFE_3_p,
  input  logic [5:0] IN_DFE_3_n,
  input  logic [5:0] IN_DFE_4_p,
  input  logic [5:0] IN_DFE_4_n,
  output logic [2:0] dc_off_adc1,
  output logic [2:0] dc_off_adc2,
  output logic [2:0] dc_off_adc3,
  output logic [2:0] dc_off_adc4,
  output logic [1:0] CH_SEL,
  output logic       BUSY,
  output logic       CAL_DONE,
  output logic       ENABLE_DFE
`ifdef DFE_CAL_SAT_FLAG_EN
  ,
  output logic [3:0] SAT_FLAG
`endif
);

  localparam int N       = 1 << ACC_LOG2;
  localparam int ACC_W   = 7 + ACC_LOG2;
  localparam int CNT_MAX = (SETTLE_CYC > N) ? SETTLE_CYC : N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] ACC_LAST    = CNT_W'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_DECIDE, S_DONE} state_t;

  function automatic logic signed [6:0] chan_diff(input logic [5:0] p, input logic [5:0] n);
    return $signed({1'b0, p}) - $signed({1'b0, n});
  endfunction

  // With no settling time a trial starts directly in ACCUM.
  function automatic state_t trial_entry();
    if (SETTLE_CYC > 0) return S_SETTLE;
    return S_ACCUM;
  endfunction

  state_t                   state, state_nx;
  logic [CNT_W-1:0]         cnt;
  logic [1:0]               ch, ch_nx;
  logic [1:0]               bit_idx, bit_nx;
  logic [2:0]               code    [4];
  logic [2:0]               code_nx [4];
  logic signed [6:0]        diff_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic                     acc_pos;
  logic                     en_r;

  always_comb begin
    diff_p0 = '0;
    case (ch)
      2'd0:    diff_p0 = chan_diff(IN_DFE_1_p, IN_DFE_1_n);
      2'd1:    diff_p0 = chan_diff(IN_DFE_2_p, IN_DFE_2_n);
      2'd2:    diff_p0 = chan_diff(IN_DFE_3_p, IN_DFE_3_n);
      default: diff_p0 = chan_diff(IN_DFE_4_p, IN_DFE_4_n);
    endcase
  end

  assign acc_pos = !acc_p1[ACC_W-1] && (acc_p1 != '0);

  always_ff @(posedge CLK) begin
    if (RES) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    bit_nx   = bit_idx;
    for (int k = 0; k < 4; k++) code_nx[k] = code[k];
    BUSY     = (state != S_IDLE);
    CAL_DONE = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nx = trial_entry();
          ch_nx    = 2'd0;
          bit_nx   = 2'd2;
          for (int k = 0; k < 4; k++) code_nx[k] = 3'd0;
          code_nx[0] = 3'b100;
        end
      end
      S_SETTLE: if (cnt == SETTLE_LAST) state_nx = S_ACCUM;
      S_ACCUM:  if (cnt == ACC_LAST) state_nx = S_DECIDE;
      S_DECIDE: begin
        // A zero sum counts as "not above": the trial bit is dropped on a tie.
        if (!acc_pos) code_nx[ch][bit_idx] = 1'b0;
        if (bit_idx != 2'd0) begin
          bit_nx = bit_idx - 2'd1;
          code_nx[ch][bit_idx - 2'd1] = 1'b1;
          state_nx = trial_entry();
        end else if (ch != 2'd3) begin
          ch_nx  = ch + 2'd1;
          bit_nx = 2'd2;
          code_nx[ch + 2'd1] = 3'b100;
          state_nx = trial_entry();
        end else begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt     <= '0;
      ch      <= 2'd0;
      bit_idx <= 2'd2;
      en_r    <= 1'b0;
      for (int k = 0; k < 4; k++) code[k] <= 3'd0;
    end else begin
      cnt     <= (state_nx != state || state == S_IDLE) ? '0 : cnt + CNT_W'(1);
      ch      <= ch_nx;
      bit_idx <= bit_nx;
      for (int k = 0; k < 4; k++) code[k] <= code_nx[k];
      if (state == S_IDLE && START)                     en_r <= 1'b0;
      else if (state == S_DECIDE && state_nx == S_DONE) en_r <= 1'b1;
    end
  end

  // Accumulate stage: p1 holds the running sum; cleared whenever not accumulating.
  always_ff @(posedge CLK) begin
    if (state == S_ACCUM) acc_p1 <= acc_p1 + ACC_W'(diff_p0);
    else                  acc_p1 <= '0;
  end

`ifdef DFE_CAL_SAT_FLAG_EN
  function automatic logic railed(input logic [2:0] c);
    return (c == 3'd0) || (c == 3'd7);
  endfunction

  logic [3:0] sat_r;

  always_ff @(posedge CLK) begin
    if (RES)                          sat_r <= 4'd0;
    else if (state == S_IDLE && START) sat_r <= 4'd0;
    else if (state == S_DECIDE && state_nx == S_DONE)
      sat_r <= {railed(code_nx[3]), railed(code_nx[2]), railed(code_nx[1]), railed(code_nx[0])};
  end

  assign SAT_FLAG = sat_r;
`endif

  assign dc_off_adc1 = code[0];
  assign dc_off_adc2 = code[1];
  assign dc_off_adc3 = code[2];
  assign dc_off_adc4 = code[3];
  assign CH_SEL      = ch;
  assign ENABLE_DFE  = en_r;

endmodule
